// File: rtl/lift_pkg.sv
// Shared lift definitions: command encodings, motion-controller states and floor width.
package lift_pkg;

  localparam int unsigned FLOOR_W = 2;
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = '1;

  typedef enum logic [1:0] {
    CMD_UP   = 2'b00,
    CMD_DOWN = 2'b01,
    CMD_STAY = 2'b10,
    CMD_RSVD = 2'b11
  } lift_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_DOOR,
    ST_DONE
  } lift_state_e;

endpackage

// File: rtl/lift_timer.sv
// 8-bit loadable down-counter; holds at zero and flags it. Shared by MOVE and DOOR phases.
module lift_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_value,
  output logic       o_zero
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/lift_motion_ctrl.sv
// Lift hoist/door sequencer: IDLE -> MOVE -> DOOR -> DONE with registered outputs.
// Optional door-obstruction reopen enabled by defining LIFT_DOOR_REOPEN_EN.
module lift_motion_ctrl
  import lift_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  output logic               cmd_ready,
  input  logic               door_reopen,
  output logic               motor_up,
  output logic               motor_dn,
  output logic               door_open,
  output logic [FLOOR_W-1:0] floor,
  output logic               arrive,
  output logic               fault
);

  // Timer counts down to zero, so a load of N-1 yields N cycles in the phase.
  localparam logic [7:0] TRAVEL_LD = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LD   = 8'(DOOR_CYCLES - 1);

  lift_state_e        r_state;
  logic               r_up;
  logic [FLOOR_W-1:0] r_floor;
  logic               r_motor_up;
  logic               r_motor_dn;
  logic               r_door_open;
  logic               r_arrive;
  logic               r_fault;
  logic               r_cmd_ready;

  lift_state_e        w_nxt_state;
  logic               w_nxt_up;
  logic [FLOOR_W-1:0] w_nxt_floor;
  logic               w_fault;
  logic               w_tmr_load;
  logic [7:0]         w_tmr_val;
  logic               w_tmr_zero;

  lift_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .o_zero  (w_tmr_zero)
  );

`ifdef LIFT_DOOR_REOPEN_EN
  // Reopen cycle counts as the first of the fresh door interval, hence N-2.
  localparam logic [7:0] DOOR_RL = 8'(DOOR_CYCLES - 2);
`else
  logic w_unused_reopen;
  assign w_unused_reopen = door_reopen;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_up    = r_up;
    w_nxt_floor = r_floor;
    w_fault     = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (lift_cmd_e'(cmd))
            CMD_UP: begin
              if (r_floor != TOP_FLOOR) begin
                w_nxt_state = ST_MOVE;
                w_nxt_up    = 1'b1;
                w_tmr_load  = 1'b1;
                w_tmr_val   = TRAVEL_LD;
              end else begin
                w_nxt_state = ST_DONE;
                w_fault     = 1'b1;
              end
            end
            CMD_DOWN: begin
              if (r_floor != '0) begin
                w_nxt_state = ST_MOVE;
                w_nxt_up    = 1'b0;
                w_tmr_load  = 1'b1;
                w_tmr_val   = TRAVEL_LD;
              end else begin
                w_nxt_state = ST_DONE;
                w_fault     = 1'b1;
              end
            end
            CMD_STAY: begin
              w_nxt_state = ST_DOOR;
              w_tmr_load  = 1'b1;
              w_tmr_val   = DOOR_LD;
            end
            default: begin
              w_nxt_state = ST_DONE;
              w_fault     = 1'b1;
            end
          endcase
        end
      end
      ST_MOVE: begin
        if (w_tmr_zero) begin
          w_nxt_state = ST_DOOR;
          w_tmr_load  = 1'b1;
          w_tmr_val   = DOOR_LD;
          w_nxt_floor = r_up ? r_floor + FLOOR_W'(1) : r_floor - FLOOR_W'(1);
        end
      end
      ST_DOOR: begin
`ifdef LIFT_DOOR_REOPEN_EN
        if (door_reopen) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = DOOR_RL;
        end else if (w_tmr_zero) begin
          w_nxt_state = ST_DONE;
        end
`else
        if (w_tmr_zero) begin
          w_nxt_state = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        w_nxt_state = ST_IDLE;
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_up        <= 1'b0;
      r_floor     <= '0;
      r_motor_up  <= 1'b0;
      r_motor_dn  <= 1'b0;
      r_door_open <= 1'b0;
      r_arrive    <= 1'b0;
      r_fault     <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_state     <= w_nxt_state;
      r_up        <= w_nxt_up;
      r_floor     <= w_nxt_floor;
      r_motor_up  <= (w_nxt_state == ST_MOVE) && w_nxt_up;
      r_motor_dn  <= (w_nxt_state == ST_MOVE) && !w_nxt_up;
      r_door_open <= (w_nxt_state == ST_DOOR);
      r_arrive    <= (w_nxt_state == ST_DONE);
      r_fault     <= w_fault;
      r_cmd_ready <= (w_nxt_state == ST_IDLE);
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign motor_up  = r_motor_up;
  assign motor_dn  = r_motor_dn;
  assign door_open = r_door_open;
  assign floor     = r_floor;
  assign arrive    = r_arrive;
  assign fault     = r_fault;

endmodule
